// File: rtl/vreg_lane_loader.sv
// Vector register file write-side loader: accepts a (base, count) load command,
// gathers 16-bit lanes over valid/ready and writes one assembled vector per register.
module vreg_lane_loader #(
    parameter int LANE_W = 16,
    parameter int LANES  = 8,
    parameter int ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_W-1:0]       cmd_rd,
    input  logic [ADDR_W-1:0]       cmd_len,
    input  logic                    lane_valid,
    output logic                    lane_ready,
    input  logic [LANE_W-1:0]       lane_data,
    input  logic                    abort,
    output logic                    we3,
    output logic [ADDR_W-1:0]       ra3,
    output logic [LANE_W*LANES-1:0] wd3,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int VEC_W = LANE_W * LANES;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'((2 ** ADDR_W) - 1);
    localparam logic [ADDR_W:0]   MAX_WR   = (ADDR_W + 1)'((2 ** ADDR_W) - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VEC_W-1:0]    buf_q, buf_d;
    logic                we3_q, we3_d;
    logic [ADDR_W-1:0]   ra3_q, ra3_d;
    logic [VEC_W-1:0]    wd3_q, wd3_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     end_reg_s;

    // Last register touched by the command, widened so an overflow cannot wrap.
    assign end_reg_s = {1'b0, cmd_rd} + {1'b0, cmd_len} - {{ADDR_W{1'b0}}, 1'b1};

    assign cmd_ready  = (state_q == ST_IDLE);
    assign lane_ready = (state_q == ST_FILL);
    assign busy       = (state_q != ST_IDLE);
    assign we3        = we3_q;
    assign ra3        = ra3_q;
    assign wd3        = wd3_q;
    assign done       = done_q;
    assign err        = err_q;

    // State register and registered write-port/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= {ADDR_W{1'b0}};
            rem_q   <= {ADDR_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            buf_q   <= {VEC_W{1'b0}};
            we3_q   <= 1'b0;
            ra3_q   <= {ADDR_W{1'b0}};
            wd3_q   <= {VEC_W{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            we3_q   <= we3_d;
            ra3_q   <= ra3_d;
            wd3_q   <= wd3_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output decode; ra3/wd3 hold between writes.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        we3_d   = 1'b0;
        ra3_d   = ra3_q;
        wd3_d   = wd3_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == {ADDR_W{1'b0}}) begin
                        done_d = 1'b1;
                    end else if ((cmd_rd == LAST_REG) || (end_reg_s > MAX_WR)) begin
                        err_d = 1'b1;
                    end else begin
                        cur_d   = cmd_rd;
                        rem_d   = cmd_len;
                        idx_d   = {IDX_W{1'b0}};
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FILL: begin
                // Abort takes priority over a coincident lane, which is dropped.
                if (abort) begin
                    err_d   = 1'b1;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_IDLE;
                end else if (lane_valid) begin
                    buf_d[idx_q*LANE_W +: LANE_W] = lane_data;
                    if (idx_q == LAST_IDX) begin
                        wd3_d   = buf_d;
                        ra3_d   = cur_q;
                        we3_d   = 1'b1;
                        idx_d   = {IDX_W{1'b0}};
                        state_d = ST_WRITE;
                    end else begin
                        idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    idx_d = idx_q;
                end
            end

            ST_WRITE: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (rem_q == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cur_d   = cur_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    rem_d   = rem_q - {{(ADDR_W-1){1'b0}}, 1'b1};
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_FILL;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vreg_lane_loader.sv
// Scoreboard bench for vreg_lane_loader: expected writes are queued as lanes are
// driven and popped by a negedge monitor whenever we3 is seen.
module tb_vreg_lane_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [3:0]   cmd_rd, cmd_len;
    logic         lane_valid, lane_ready;
    logic [15:0]  lane_data;
    logic         abort;
    logic         we3;
    logic [3:0]   ra3;
    logic [127:0] wd3;
    logic         busy, done, err;

    int vectors = 0;
    int miscompares = 0;
    int we_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [131:0] sb_q[$];
    logic [131:0] exp_w;

    always #5 clk = ~clk;

    vreg_lane_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_len(cmd_len),
        .lane_valid(lane_valid), .lane_ready(lane_ready), .lane_data(lane_data),
        .abort(abort), .we3(we3), .ra3(ra3), .wd3(wd3),
        .busy(busy), .done(done), .err(err)
    );

    // Monitor: pops the scoreboard on each write and tallies done/err pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (we3) begin
                we_cnt++;
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write ra3=%0d wd3=%h", ra3, wd3);
                end else begin
                    exp_w = sb_q.pop_front();
                    if ({ra3, wd3} !== exp_w) begin
                        miscompares++;
                        $display("FAIL write ra3=%0d wd3=%h expected ra3=%0d wd3=%h",
                                 ra3, wd3, exp_w[131:128], exp_w[127:0]);
                    end
                end
                vectors++;
                if (lane_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lane_ready_in_write got=%b expected=0", lane_ready);
                end
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (done || err) begin
                vectors++;
                if (done && err) begin
                    miscompares++;
                    $display("FAIL done_err_overlap done=%b err=%b expected one-hot", done, err);
                end
            end
        end
    end

    task automatic clear_counts();
        we_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic send_cmd(input logic [3:0] rd, input logic [3:0] len);
        int n = 0;
        cmd_valid = 1'b1; cmd_rd = rd; cmd_len = len;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++; miscompares++;
            $display("FAIL cmd_timeout cmd_ready=%b expected=1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_lane(input logic [15:0] d, input bit stall);
        int n = 0;
        if (stall && $urandom_range(0, 1) == 1) begin
            lane_valid = 1'b0;
            @(posedge clk); #1;
        end
        lane_valid = 1'b1; lane_data = d;
        @(negedge clk);
        while (lane_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++; miscompares++;
            $display("FAIL lane_timeout lane_ready=%b expected=1", lane_ready);
        end
        @(posedge clk); #1;
    endtask

    // Full command with generated lanes; expected vectors queued as lanes go out.
    task automatic load(input logic [3:0] rd, input logic [3:0] len,
                        input logic [15:0] base, input bit stall);
        logic [127:0] v;
        send_cmd(rd, len);
        for (int r = 0; r < int'(len); r++) begin
            for (int i = 0; i < 8; i++) v[i*16 +: 16] = base + 16'(r*8 + i);
            sb_q.push_back({4'(int'(rd) + r), v});
            for (int i = 0; i < 8; i++) send_lane(v[i*16 +: 16], stall);
        end
        lane_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_rd = 4'd0; cmd_len = 4'd0;
        lane_valid = 1'b0; lane_data = 16'd0; abort = 1'b0;
        #12;
        vectors++;
        if ({we3, ra3, wd3, done, err, busy, lane_ready, cmd_ready} !== {1'b0, 4'd0, 128'd0, 5'b00001}) begin
            miscompares++;
            $display("FAIL reset we3=%b ra3=%0d wd3=%h done=%b err=%b busy=%b lane_ready=%b cmd_ready=%b expected zeros/cmd_ready=1",
                     we3, ra3, wd3, done, err, busy, lane_ready, cmd_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [15:0] lanes [8] = '{16'h000A, 16'h0008, 16'h0003, 16'h000B,
                                   16'h0001, 16'h0005, 16'h000F, 16'h000C};
        clear_counts();
        sb_q.push_back({4'd0, 128'h000C000F00050001000B00030008000A});
        send_cmd(4'd0, 4'd1);
        for (int i = 0; i < 8; i++) send_lane(lanes[i], 1'b0);
        lane_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        vectors++;
        if (we_cnt !== 1 || done_cnt !== 1 || err_cnt !== 0 || sb_q.size() != 0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single we=%0d done=%0d err=%0d pending=%0d cmd_ready=%b expected 1/1/0/0/1",
                     we_cnt, done_cnt, err_cnt, sb_q.size(), cmd_ready);
        end
    endtask

    task automatic test_two_regs();
        clear_counts();
        sb_q.push_back({4'd3, 128'h00080007000600050004000300020001});
        sb_q.push_back({4'd4, 128'h0010000F000E000D000C000B000A0009});
        send_cmd(4'd3, 4'd2);
        for (int i = 1; i <= 16; i++) send_lane(16'(i), 1'b0);
        lane_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        vectors++;
        if (we_cnt !== 2 || done_cnt !== 1 || err_cnt !== 0 || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL two_regs we=%0d done=%0d err=%0d pending=%0d expected 2/1/0/0",
                     we_cnt, done_cnt, err_cnt, sb_q.size());
        end
    endtask

    task automatic test_stall();
        logic [15:0] lanes [8] = '{16'h000A, 16'h0008, 16'h0003, 16'h000B,
                                   16'h0001, 16'h0005, 16'h000F, 16'h000C};
        clear_counts();
        sb_q.push_back({4'd14, 128'h000C000F00050001000B00030008000A});
        send_cmd(4'd14, 4'd1);
        for (int i = 0; i < 8; i++) send_lane(lanes[i], 1'b1);
        lane_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        vectors++;
        if (we_cnt !== 1 || done_cnt !== 1 || err_cnt !== 0 || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall we=%0d done=%0d err=%0d pending=%0d expected 1/1/0/0",
                     we_cnt, done_cnt, err_cnt, sb_q.size());
        end
    endtask

    task automatic test_reject();
        logic [3:0] rds  [3] = '{4'd15, 4'd10, 4'd0};
        logic [3:0] lens [3] = '{4'd1,  4'd6,  4'd0};
        for (int k = 0; k < 3; k++) begin
            clear_counts();
            send_cmd(rds[k], lens[k]);
            repeat (3) @(posedge clk); #1;
            vectors++;
            if (we_cnt !== 0 || done_cnt !== (k == 2 ? 1 : 0) || err_cnt !== (k == 2 ? 0 : 1) || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reject_%0d we=%0d done=%0d err=%0d busy=%b expected 0/%0d/%0d/0",
                         k, we_cnt, done_cnt, err_cnt, busy, (k == 2 ? 1 : 0), (k == 2 ? 0 : 1));
            end
        end
        // Upper boundary: registers 12..14 are all writable.
        clear_counts();
        load(4'd12, 4'd3, 16'h5000, 1'b0);
        repeat (3) @(posedge clk); #1;
        vectors++;
        if (we_cnt !== 3 || done_cnt !== 1 || err_cnt !== 0 || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL boundary we=%0d done=%0d err=%0d pending=%0d expected 3/1/0/0",
                     we_cnt, done_cnt, err_cnt, sb_q.size());
        end
    endtask

    task automatic test_abort();
        logic [127:0] v;
        clear_counts();
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'h2000 + 16'(i);
        sb_q.push_back({4'd2, v});
        send_cmd(4'd2, 4'd3);
        for (int i = 0; i < 8; i++) send_lane(v[i*16 +: 16], 1'b0);
        for (int i = 0; i < 5; i++) send_lane(16'h3000 + 16'(i), 1'b0);
        abort = 1'b1; lane_valid = 1'b1; lane_data = 16'hDEAD;
        @(posedge clk); #1;
        abort = 1'b0; lane_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        vectors++;
        if (we_cnt !== 1 || done_cnt !== 0 || err_cnt !== 1 || sb_q.size() != 0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort we=%0d done=%0d err=%0d pending=%0d cmd_ready=%b expected 1/0/1/0/1",
                     we_cnt, done_cnt, err_cnt, sb_q.size(), cmd_ready);
        end
        clear_counts();
        load(4'd7, 4'd1, 16'h7700, 1'b0);
        repeat (3) @(posedge clk); #1;
        vectors++;
        if (we_cnt !== 1 || done_cnt !== 1 || err_cnt !== 0 || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL after_abort we=%0d done=%0d err=%0d pending=%0d expected 1/1/0/0",
                     we_cnt, done_cnt, err_cnt, sb_q.size());
        end
    endtask

    task automatic test_async_reset();
        send_cmd(4'd1, 4'd1);
        for (int i = 0; i < 3; i++) send_lane(16'h0900 + 16'(i), 1'b0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({we3, ra3, wd3, busy, lane_ready} !== {1'b0, 4'd0, 128'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset we3=%b ra3=%0d wd3=%h busy=%b lane_ready=%b expected all 0",
                     we3, ra3, wd3, busy, lane_ready);
        end
        lane_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        clear_counts();
        repeat (20) @(posedge clk); #1;
        vectors++;
        if (we_cnt !== 0 || done_cnt !== 0 || err_cnt !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset we=%0d done=%0d err=%0d busy=%b expected 0/0/0/0",
                     we_cnt, done_cnt, err_cnt, busy);
        end
        clear_counts();
        load(4'd0, 4'd1, 16'hA000, 1'b0);
        repeat (3) @(posedge clk); #1;
        vectors++;
        if (we_cnt !== 1 || done_cnt !== 1 || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL reload we=%0d done=%0d pending=%0d expected 1/1/0",
                     we_cnt, done_cnt, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_regs();
        test_stall();
        test_reject();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vreg_lane_loader.md
Name: vreg_lane_loader

Overview:
- Write-side producer for the 128-bit vector register file (15 writable registers r0..r14; r15 is externally supplied and not writable).
- Accepts a load command (base register, register count), then collects 16-bit lanes from a narrow memory/stream source over valid/ready.
- Assembles each 8-lane vector and issues one write strobe per vector on the register file write port (we3/ra3/wd3).
- Sits between the vector load path and the register file write port.

Parameters:
LANE_W, 16, width of one lane in bits
LANES, 8, lanes per vector; vector width = LANE_W*LANES = 128
ADDR_W, 4, register address width; address 2**ADDR_W-1 (15) is not writable

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  load command valid
cmd_ready  out  1  loader can accept a command
cmd_rd  in  4  first destination register
cmd_len  in  4  number of consecutive registers to load, 0..15
lane_valid  in  1  lane data valid
lane_ready  out  1  loader accepts a lane this cycle
lane_data  in  16  lane payload
abort  in  1  synchronous abort of the current command
we3  out  1  register file write enable
ra3  out  4  register file write address
wd3  out  128  register file write data
busy  out  1  command in progress
done  out  1  one-cycle pulse: command completed
err  out  1  one-cycle pulse: command rejected or aborted

Behaviour:
- Reset, asynchronous and active-high: state = IDLE; we3=0, ra3=0, wd3=0, done=0, err=0, lane index=0, internal counters=0. Reset mid-command discards partial lanes. No write is issued during or after reset.
- All outputs are registered from posedge clk. The register file samples on negedge, so we3/ra3/wd3 are stable across that edge.
- cmd_ready = (state==IDLE). lane_ready = (state==FILL). busy = (state!=IDLE).
- A transfer on either handshake occurs only when valid && ready at a posedge.
- IDLE, on command accept:
  - cmd_len==0: done pulses the next cycle; stay IDLE; no write.
  - cmd_rd==15, or cmd_rd+cmd_len-1 > 14 (computed 5-bit, no wrap): err pulses the next cycle; stay IDLE; no write.
  - Otherwise: latch cur=cmd_rd and rem=cmd_len; set lane index 0; go to FILL.
- FILL:
  - Each accepted lane is stored at bits [16*i+15 : 16*i] of the assembly buffer; i increments.
  - On acceptance of lane 7: wd3 <= full buffer, ra3 <= cur, we3 <= 1; go to WRITE.
  - Lanes are never overwritten before the write, and lanes are not skipped on stalls.
- WRITE (exactly one cycle, we3=1, lane_ready=0):
  - rem==1: we3 <= 0, done pulse, go to IDLE.
  - Otherwise: cur++, rem--, i=0, we3 <= 0, go to FILL.
- Latency: the last lane is accepted at posedge k; we3=1 for the cycle k..k+1. Minimum 9 cycles per register at full lane throughput (8 FILL + 1 WRITE).
- ra3/wd3 hold their last written values while we3=0.
- abort, sampled in FILL or WRITE: a write already registered (we3 currently 1) completes this cycle. The partial buffer is discarded, err pulses, and the state returns to IDLE. Abort in IDLE is ignored. If abort and a lane handshake coincide, abort wins and the lane is dropped.
- done and err are never asserted together. Each pulse lasts exactly one cycle.

Test Plan:
1. Reset, then cmd_rd=0, cmd_len=1, lanes 000A,0008,0003,000B,0001,0005,000F,000C streamed back-to-back -> single we3 pulse with ra3=0, wd3=128'h000C000F00050001000B00030008000A; done pulse next cycle; cmd_ready returns to 1.
2. cmd_rd=3, cmd_len=2, 16 lanes 0x0001..0x0010 -> we3 with ra3=3, wd3=128'h0008000700060005000400030002_0001, then ra3=4, wd3=128'h0010000F000E000D000C000B000A0009; exactly 2 we3 pulses; then done.
3. lane_valid toggled randomly (50%) with cmd_rd=14, cmd_len=1 -> identical wd3 to the no-stall case; lane_ready low during the WRITE cycle.
4. cmd_rd=15, cmd_len=1, and separately cmd_rd=10, cmd_len=6 -> err pulse, no we3, state stays IDLE. cmd_len=0 -> done pulse, no we3.
5. abort asserted after 5 lanes of the second register of a cmd_len=3 command -> first register written, no further we3, err pulse, IDLE; the next command assembles correctly from lane 0.
6. rst asserted asynchronously mid-FILL (between clock edges) -> we3, ra3, wd3 go to 0 immediately, busy=0; no write occurs after release.
